// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM arbiter: FSM state encoding, grant history and strobe timing defaults.
package sram_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_ACCESS = 3'd1,
        WR_SETUP  = 3'd2,
        WR_PULSE  = 3'd3,
        WR_HOLD   = 3'd4,
        RECOVER   = 3'd5
    } sram_state_t;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_t;

    localparam int DEFAULT_ACCESS_CYCLES = 2;
    localparam int MAX_ACCESS_CYCLES     = 15;
    localparam int STROBE_CNT_W          = 4;

endpackage

// File: rtl/sram_strobe_timer.sv
// Down-counter that times one strobe phase; done is high once the reloaded count reaches zero.
module sram_strobe_timer
    import sram_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [STROBE_CNT_W-1:0] load_val,
    output logic                    done
);

    logic [STROBE_CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign done = (count == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin read/write arbiter driving an asynchronous single-port SRAM with programmable strobe width.
// Define SRAM_BOUNDS_CHECK_EN to reject addresses >= sram_capacity with *_invalid pulses.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int data_width      = 16,
    parameter int sram_addr_width = 12,
    parameter int sram_capacity   = 4096,
    parameter int access_cycles   = DEFAULT_ACCESS_CYCLES
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_sram_read,
    input  logic                       req_sram_write,
    input  logic [sram_addr_width-1:0] req_sram_read_addr,
    input  logic [sram_addr_width-1:0] req_sram_write_addr,
    input  logic [data_width-1:0]      data_to_sram,
    output logic                       sram_read_ready,
    output logic                       sram_write_ready,
    output logic [data_width-1:0]      data_from_sram,
    output logic                       sram_read_invalid,
    output logic                       sram_write_invalid,
    output logic [sram_addr_width-1:0] sram_addr,
    output logic [data_width-1:0]      sram_dq_out,
    output logic                       sram_dq_oe,
    input  logic [data_width-1:0]      sram_dq_in,
    output logic                       sram_ce_n,
    output logic                       sram_oe_n,
    output logic                       sram_we_n
);

    localparam logic [STROBE_CNT_W-1:0] STROBE_RELOAD = STROBE_CNT_W'(access_cycles - 1);

    sram_state_t                state;
    grant_t                     last_grant;
    logic                       grant_rd, grant_wr;
    logic                       strobe_load, strobe_done;
    logic [sram_addr_width-1:0] rd_addr_eff, wr_addr_eff;

`ifdef SRAM_BOUNDS_CHECK_EN
    localparam logic [sram_addr_width:0] CAP_LIMIT = (sram_addr_width+1)'(sram_capacity);

    logic rd_oob, wr_oob;
    logic rd_inv_q, wr_inv_q;

    assign rd_addr_eff        = req_sram_read_addr;
    assign wr_addr_eff        = req_sram_write_addr;
    assign rd_oob             = ({1'b0, req_sram_read_addr}  >= CAP_LIMIT);
    assign wr_oob             = ({1'b0, req_sram_write_addr} >= CAP_LIMIT);
    assign sram_read_invalid  = rd_inv_q;
    assign sram_write_invalid = wr_inv_q;
`else
    // Unchecked build: addresses wrap onto the power-of-two span covering the capacity.
    localparam int CAP_AW = $clog2(sram_capacity);
    localparam logic [sram_addr_width-1:0] ADDR_MASK =
        (CAP_AW >= sram_addr_width) ? '1 : sram_addr_width'((64'd1 << CAP_AW) - 64'd1);

    assign rd_addr_eff        = req_sram_read_addr  & ADDR_MASK;
    assign wr_addr_eff        = req_sram_write_addr & ADDR_MASK;
    assign sram_read_invalid  = 1'b0;
    assign sram_write_invalid = 1'b0;
`endif

    // On a tie the type not served last wins; a lone request always wins.
    assign grant_rd = req_sram_read && (!req_sram_write || last_grant == GRANT_WRITE);
    assign grant_wr = req_sram_write && !grant_rd;

    // RD_ACCESS is only entered from IDLE and WR_PULSE only from WR_SETUP.
    assign strobe_load = (state == IDLE) || (state == WR_SETUP);

    sram_strobe_timer u_strobe (
        .clk      (clk),
        .reset    (reset),
        .load     (strobe_load),
        .load_val (STROBE_RELOAD),
        .done     (strobe_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            last_grant       <= GRANT_WRITE;
            sram_read_ready  <= 1'b0;
            sram_write_ready <= 1'b0;
            data_from_sram   <= '0;
            sram_addr        <= '0;
            sram_dq_out      <= '0;
            sram_dq_oe       <= 1'b0;
            sram_ce_n        <= 1'b1;
            sram_oe_n        <= 1'b1;
            sram_we_n        <= 1'b1;
`ifdef SRAM_BOUNDS_CHECK_EN
            rd_inv_q         <= 1'b0;
            wr_inv_q         <= 1'b0;
`endif
        end else begin
            sram_read_ready  <= 1'b0;
            sram_write_ready <= 1'b0;
`ifdef SRAM_BOUNDS_CHECK_EN
            rd_inv_q         <= 1'b0;
            wr_inv_q         <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (grant_rd) begin
                        last_grant <= GRANT_READ;
`ifdef SRAM_BOUNDS_CHECK_EN
                        if (rd_oob) begin
                            rd_inv_q <= 1'b1;
                            state    <= RECOVER;
                        end else
`endif
                        begin
                            sram_addr <= rd_addr_eff;
                            sram_ce_n <= 1'b0;
                            sram_oe_n <= 1'b0;
                            state     <= RD_ACCESS;
                        end
                    end else if (grant_wr) begin
                        last_grant <= GRANT_WRITE;
`ifdef SRAM_BOUNDS_CHECK_EN
                        if (wr_oob) begin
                            wr_inv_q <= 1'b1;
                            state    <= RECOVER;
                        end else
`endif
                        begin
                            sram_addr   <= wr_addr_eff;
                            sram_dq_out <= data_to_sram;
                            sram_dq_oe  <= 1'b1;
                            sram_ce_n   <= 1'b0;
                            state       <= WR_SETUP;
                        end
                    end
                end
                RD_ACCESS: begin
                    if (strobe_done) begin
                        data_from_sram  <= sram_dq_in;
                        sram_ce_n       <= 1'b1;
                        sram_oe_n       <= 1'b1;
                        sram_read_ready <= 1'b1;
                        state           <= RECOVER;
                    end
                end
                WR_SETUP: begin
                    sram_we_n <= 1'b0;
                    state     <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (strobe_done) begin
                        sram_we_n <= 1'b1;
                        state     <= WR_HOLD;
                    end
                end
                WR_HOLD: begin
                    sram_dq_oe       <= 1'b0;
                    sram_ce_n        <= 1'b1;
                    sram_write_ready <= 1'b1;
                    state            <= RECOVER;
                end
                // Upstream still holds req this cycle; ignoring it avoids a double service.
                RECOVER: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    a_no_bus_fight: assert property (@(posedge clk) disable iff (reset) !(sram_dq_oe && !sram_oe_n));

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench: pin-level SRAM model plus a transaction-level reference of memory and grant order.
module tb_sram_arbiter;

    localparam int DW     = 16;
    localparam int AW     = 12;
    localparam int CAP    = 4000;
    localparam int AC     = 2;
    localparam int RD_LAT = AC + 1;
    localparam int WR_LAT = AC + 3;

    logic          clk, reset;
    logic          req_sram_read, req_sram_write;
    logic [AW-1:0] req_sram_read_addr, req_sram_write_addr;
    logic [DW-1:0] data_to_sram;
    logic          sram_read_ready, sram_write_ready, sram_read_invalid, sram_write_invalid;
    logic [DW-1:0] data_from_sram, sram_dq_out, sram_dq_in;
    logic [AW-1:0] sram_addr;
    logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    logic [DW-1:0] mem     [0:4095];
    logic [DW-1:0] ref_mem [0:4095];
    bit            last_was_read;
    int            n_checks, n_fail;

    sram_arbiter #(
        .data_width      (DW),
        .sram_addr_width (AW),
        .sram_capacity   (CAP),
        .access_cycles   (AC)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .req_sram_read       (req_sram_read),
        .req_sram_write      (req_sram_write),
        .req_sram_read_addr  (req_sram_read_addr),
        .req_sram_write_addr (req_sram_write_addr),
        .data_to_sram        (data_to_sram),
        .sram_read_ready     (sram_read_ready),
        .sram_write_ready    (sram_write_ready),
        .data_from_sram      (data_from_sram),
        .sram_read_invalid   (sram_read_invalid),
        .sram_write_invalid  (sram_write_invalid),
        .sram_addr           (sram_addr),
        .sram_dq_out         (sram_dq_out),
        .sram_dq_oe          (sram_dq_oe),
        .sram_dq_in          (sram_dq_in),
        .sram_ce_n           (sram_ce_n),
        .sram_oe_n           (sram_oe_n),
        .sram_we_n           (sram_we_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Asynchronous SRAM: drives data while selected for read, captures on the rising edge of we_n.
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n && !sram_dq_oe) ? mem[sram_addr] : 16'hDEAD;
    always @(posedge sram_we_n)
        if (reset === 1'b0 && sram_ce_n === 1'b0 && sram_dq_oe === 1'b1)
            mem[sram_addr] = sram_dq_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] eff_addr(input logic [AW-1:0] a);
        return AW'(int'(a) % (1 << $clog2(CAP)));
    endfunction

    function automatic bit is_oob(input logic [AW-1:0] a);
`ifdef SRAM_BOUNDS_CHECK_EN
        return int'(a) >= CAP;
`else
        return (a != a);
`endif
    endfunction

    function automatic int any_activity();
        return int'(!sram_ce_n) + int'(sram_read_ready) + int'(sram_write_ready)
             + int'(sram_read_invalid) + int'(sram_write_invalid);
    endfunction

    // One request from an idle arbiter; req is held for one cycle after the response, as upstream does.
    task automatic txn(input bit is_wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        int k, rdy_k, inv_k, ce_lo, strobe_lo, first_we, last_we, bad_pins, overlap, spur;
        bit oob;
        logic [AW-1:0] pa;
        logic [DW-1:0] rd_data;
        oob = is_oob(addr);
        pa  = eff_addr(addr);
        k = 0; rdy_k = 0; inv_k = 0; ce_lo = 0; strobe_lo = 0;
        first_we = 0; last_we = 0; bad_pins = 0; overlap = 0; spur = 0;
        rd_data = '0;
        if (is_wr) begin
            req_sram_write = 1'b1; req_sram_write_addr = addr; data_to_sram = wdata;
        end else begin
            req_sram_read = 1'b1; req_sram_read_addr = addr;
        end
        while (rdy_k == 0 && inv_k == 0 && k < 40) begin
            @(negedge clk);
            k++;
            if (!sram_ce_n) begin
                ce_lo++;
                if (sram_addr !== pa) bad_pins++;
                if (is_wr && (sram_dq_oe !== 1'b1 || sram_dq_out !== wdata)) bad_pins++;
            end
            if (is_wr ? !sram_we_n : !sram_oe_n) strobe_lo++;
            if (!sram_we_n) begin
                if (first_we == 0) first_we = k;
                last_we = k;
            end
            if (sram_dq_oe && !sram_oe_n) overlap++;
            if (is_wr ? (sram_read_ready || sram_read_invalid)
                      : (sram_write_ready || sram_write_invalid)) spur++;
            if (is_wr ? sram_write_ready : sram_read_ready) begin
                rdy_k = k; rd_data = data_from_sram;
            end
            if (is_wr ? sram_write_invalid : sram_read_invalid) inv_k = k;
        end
        last_was_read = !is_wr;
        @(negedge clk);
        spur += any_activity();
        req_sram_read = 1'b0; req_sram_write = 1'b0;
        repeat (2) begin
            @(negedge clk);
            spur += any_activity();
        end
        if (oob) begin
            check("inv_latency", inv_k, 1);
            check("inv_no_strobe", ce_lo, 0);
            check("inv_no_ready", rdy_k, 0);
        end else begin
            if (is_wr) check("wr_latency", rdy_k, WR_LAT);
            else       check("rd_latency", rdy_k, RD_LAT);
            check("strobe_len", strobe_lo, AC);
            check("ce_len", ce_lo, is_wr ? AC + 2 : AC);
            check("pin_stable", bad_pins, 0);
            if (is_wr) begin
                check("we_start", first_we, 2);
                check("we_end", last_we, AC + 1);
                ref_mem[pa] = wdata;
                check("mem_write", 32'(mem[pa]), 32'(ref_mem[pa]));
            end else begin
                check("rd_data", 32'(rd_data), 32'(ref_mem[pa]));
            end
        end
        check("no_extra_activity", spur, 0);
        check("oe_dq_overlap", overlap, 0);
    endtask

    // Both requests held continuously; grants must alternate and follow back-to-back.
    task automatic tie_rounds(input int grants);
        logic [AW-1:0] ra, wa;
        logic [DW-1:0] wd, rd_data;
        int gap;
        bit exp_wr, got_wr, got_any, first;
        ra = AW'($urandom_range(0, 1023));
        wa = ra + AW'(1024);
        wd = DW'($urandom);
        rd_data = '0;
        req_sram_read = 1'b1;  req_sram_read_addr  = ra;
        req_sram_write = 1'b1; req_sram_write_addr = wa; data_to_sram = wd;
        first = 1'b1;
        for (int g = 0; g < grants; g++) begin
            exp_wr = last_was_read;
            gap = 0; got_any = 1'b0; got_wr = 1'b0;
            while (!got_any && gap < 40) begin
                @(negedge clk);
                gap++;
                if (sram_read_ready || sram_write_ready) begin
                    got_any = 1'b1;
                    got_wr  = sram_write_ready;
                    rd_data = data_from_sram;
                end
            end
            check("tie_order", 32'(got_wr), 32'(exp_wr));
            check("tie_gap", gap, (exp_wr ? WR_LAT : RD_LAT) + (first ? 0 : 1));
            if (exp_wr) ref_mem[wa] = wd;
            else        check("tie_rd_data", 32'(rd_data), 32'(ref_mem[ra]));
            last_was_read = !exp_wr;
            first = 1'b0;
        end
        @(negedge clk);
        req_sram_read = 1'b0; req_sram_write = 1'b0;
        repeat (2) @(negedge clk);
        check("tie_mem", 32'(mem[wa]), 32'(wd));
    endtask

    initial begin
        bit            w;
        logic [AW-1:0] a;
        int            cnt;
        n_checks = 0; n_fail = 0;
        reset = 1'b1;
        req_sram_read = 1'b0; req_sram_write = 1'b0;
        req_sram_read_addr = '0; req_sram_write_addr = '0; data_to_sram = '0;
        last_was_read = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = DW'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[12'h010] = 16'hBEEF; ref_mem[12'h010] = 16'hBEEF;
        repeat (2) @(negedge clk);

        check("rst_ce_n", 32'(sram_ce_n), 1);
        check("rst_oe_n", 32'(sram_oe_n), 1);
        check("rst_we_n", 32'(sram_we_n), 1);
        check("rst_dq_oe", 32'(sram_dq_oe), 0);
        check("rst_pulses", 32'({sram_read_ready, sram_write_ready, sram_read_invalid, sram_write_invalid}), 0);
        check("rst_rdata", 32'(data_from_sram), 0);
        check("rst_addr", 32'(sram_addr), 0);
        check("rst_dq_out", 32'(sram_dq_out), 0);
        reset = 1'b0;
        @(negedge clk);

        tie_rounds(20);

        txn(1'b0, 12'h010, 16'h0000);
        check("read_beef", 32'(data_from_sram), 32'h0000BEEF);
        txn(1'b1, 12'h0FF, 16'h1234);
        check("mem_0ff", 32'(mem[12'h0FF]), 32'h00001234);
        txn(1'b1, 12'h005, 16'hA5A5);
        txn(1'b0, 12'h005, 16'h0000);
        check("read_a5a5", 32'(data_from_sram), 32'h0000A5A5);

        // Boundary: first address past the capacity, and the top of the address space.
        txn(1'b0, AW'(CAP), 16'h0000);
        tie_rounds(2);
        txn(1'b1, 12'hFFF, 16'h0F0F);
        txn(1'b0, AW'(CAP - 1), 16'h0000);

        for (int i = 0; i < 30; i++) begin
            w = 1'(($urandom >> 3) & 1);
            a = (($urandom & 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom);
            txn(w, a, DW'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of the write strobe.
        req_sram_write = 1'b1; req_sram_write_addr = 12'h033; data_to_sram = 16'h7E7E;
        repeat (2) @(negedge clk);
        check("pre_rst_we_low", 32'(sram_we_n), 0);
        #2 reset = 1'b1;
        req_sram_write = 1'b0;
        #1;
        check("rst_async_we", 32'(sram_we_n), 1);
        check("rst_async_dq_oe", 32'(sram_dq_oe), 0);
        check("rst_async_ce", 32'(sram_ce_n), 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        last_was_read = 1'b0;
        cnt = 0;
        repeat (AC + 6) begin
            @(negedge clk);
            cnt += any_activity();
        end
        check("rst_no_ready", cnt, 0);
        txn(1'b0, 12'h010, 16'h0000);
        txn(1'b1, 12'h033, 16'h55AA);
        txn(1'b0, 12'h033, 16'h0000);
        check("post_rst_rd", 32'(data_from_sram), 32'h000055AA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
